// File: rtl/mem_arbiter.sv
// Byte-wide RAM port shared between instruction fetch and the MEM stage.
// Sequences 1/2/4-byte little-endian transfers, one byte per cycle.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic              mem_sign,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              stallreq_if,
    output logic              stallreq_mem
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WAIT,
        DONE
    } state_t;

    state_t            state;
    logic              own_mem;
    logic              we_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata_q;
    logic [2:0]        cnt;
    logic [31:0]       rbuf;
    logic              flush_q;

    logic [2:0]        nbytes;
    logic [2:0]        last;
    logic              cap_en;
    logic [1:0]        cap_idx;
    logic [31:0]       word;
    logic [31:0]       rext;
    logic              busy_done;

    always_comb begin
        nbytes = 3'd4;
        if (size_q == 2'd1) nbytes = 3'd1;
        else if (size_q == 2'd2) nbytes = 3'd2;
    end

    assign last = nbytes - 3'd1;

    // Read data lags its address by two edges: one for the
    // registered address, one for the RAM's registered output.
    always_comb begin
        cap_en  = 1'b0;
        cap_idx = 2'd0;
        if (!we_q) begin
            if (state == XFER && cnt >= 3'd2) begin
                cap_en  = 1'b1;
                cap_idx = 2'(cnt - 3'd2);
            end else if (state == WAIT && nbytes >= 3'd2) begin
                cap_en  = 1'b1;
                cap_idx = 2'(nbytes - 3'd2);
            end
        end
    end

    always_comb begin
        word = rbuf;
        word[8*last[1:0] +: 8] = ram_din;
    end

    always_comb begin
        rext = word;
        if (nbytes == 3'd1)
            rext = {{24{sign_q & word[7]}}, word[7:0]};
        else if (nbytes == 3'd2)
            rext = {{16{sign_q & word[15]}}, word[15:0]};
    end

    // The done cycle is held off arbitration so a requester
    // still holding req for the finished transfer is not re-accepted.
    assign busy_done = if_done | mem_done;

    assign stallreq_if  = if_req && !if_done;
    assign stallreq_mem = mem_req && !mem_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            own_mem   <= 1'b0;
            we_q      <= 1'b0;
            size_q    <= 2'd0;
            sign_q    <= 1'b0;
            base      <= '0;
            wdata_q   <= 32'd0;
            cnt       <= 3'd0;
            rbuf      <= 32'd0;
            flush_q   <= 1'b0;
            ram_addr  <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= 8'd0;
            if_rdata  <= 32'd0;
            mem_rdata <= 32'd0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            if (cap_en)
                rbuf[8*cap_idx +: 8] <= ram_din;
            if (state != IDLE && !own_mem && if_flush)
                flush_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (!busy_done) begin
                        if (mem_req) begin
                            own_mem <= 1'b1;
                            we_q    <= mem_we;
                            size_q  <= mem_size;
                            sign_q  <= mem_sign;
                            base    <= mem_addr;
                            wdata_q <= mem_wdata;
                            cnt     <= 3'd0;
                            state   <= XFER;
                        end else if (if_req && !if_flush) begin
                            own_mem <= 1'b0;
                            we_q    <= 1'b0;
                            size_q  <= 2'd0;
                            sign_q  <= 1'b0;
                            base    <= if_addr;
                            cnt     <= 3'd0;
                            state   <= XFER;
                        end
                    end
                end
                XFER: begin
                    ram_addr <= base + ADDR_W'(cnt);
                    ram_wr   <= we_q;
                    ram_dout <= we_q ? wdata_q[8*cnt[1:0] +: 8] : 8'd0;
                    cnt      <= cnt + 3'd1;
                    if (cnt == last)
                        state <= we_q ? DONE : WAIT;
                end
                WAIT: begin
                    ram_wr <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    ram_wr  <= 1'b0;
                    flush_q <= 1'b0;
                    state   <= IDLE;
                    if (own_mem) begin
                        mem_done <= 1'b1;
                        if (!we_q)
                            mem_rdata <= rext;
                    end else if (!(flush_q || if_flush)) begin
                        if_done  <= 1'b1;
                        if_rdata <= word;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
